// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
//
// Turns one register-access request (write byte to register R of device D,
// or read byte from register R of device D) into the level-held
// start/stop/read/write control sequence of an i2c_master, and returns one
// response per request. One transaction in flight at a time.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_rw                    0 = register write, 1 = register read
//   req_dev, req_reg          7-bit device address, register pointer
//   req_wdata                 write data (ignored for reads)
//   rsp_valid                 one-cycle pulse when a transaction finishes
//   rsp_rdata, rsp_err        read byte / status (0 OK, 1 NACK, 2 timeout)
//   m_start/m_stop/m_read/m_write, m_addr, m_tx_data
//                             registered, level-held master controls
//   m_busy, m_ready, m_ack, m_rx_data
//                             master status and received byte
// ---------------------------------------------------------------------------
module i2c_reg_sequencer #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_read,
    output logic       m_write,
    output logic [6:0] m_addr,
    output logic [7:0] m_tx_data,
    input  logic       m_busy,
    input  logic       m_ready,
    input  logic       m_ack,
    input  logic [7:0] m_rx_data
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ST_A    = 4'd1;
    localparam logic [3:0] S_PTR     = 4'd2;
    localparam logic [3:0] S_PTR_ACK = 4'd3;
    localparam logic [3:0] S_WDAT    = 4'd4;
    localparam logic [3:0] S_STOP1   = 4'd5;
    localparam logic [3:0] S_ST_B    = 4'd6;
    localparam logic [3:0] S_RADR    = 4'd7;
    localparam logic [3:0] S_RDAT    = 4'd8;
    localparam logic [3:0] S_STOP_F  = 4'd9;
    localparam logic [3:0] S_RESP    = 4'd10;

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             rw_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rdata_q;
    logic             err_q;

    logic ev;          // byte/ACK boundary reported by the master
    logic busy_rise;   // master has taken the START
    logic advance;     // current state's exit condition holds
    logic timeout_hit;

    assign ev          = m_ready && m_busy;
    assign busy_rise   = m_busy && !busy_q;
    // A progress event in the expiry cycle takes priority over the abort.
    assign timeout_hit = (state != S_IDLE) && (state != S_RESP) && !ev &&
                         (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Every state leaves on exactly one condition, so "advance" doubles as
    // the state-change indication that clears the timeout counter.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // the signal unassigned and infers a latch.
        advance = 1'b0;
        unique case (state)
            S_IDLE:                                  advance = req_valid && req_ready;
            S_ST_A, S_ST_B:                          advance = busy_rise;
            S_PTR, S_PTR_ACK, S_WDAT, S_RADR, S_RDAT: advance = ev;
            S_STOP1, S_STOP_F:                       advance = !m_busy;
            default:                                 advance = 1'b1;  // S_RESP
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_IDLE || advance || ev || timeout_hit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
            m_start   <= 1'b0;
            m_stop    <= 1'b0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            m_addr    <= '0;
            m_tx_data <= '0;
        end else begin
            busy_q <= m_busy;
            if (timeout_hit) begin
                m_start   <= 1'b0;
                m_stop    <= 1'b0;
                m_read    <= 1'b0;
                m_write   <= 1'b0;
                m_addr    <= '0;
                m_tx_data <= '0;
                rsp_valid <= 1'b1;
                rsp_err   <= 2'd2;
                rsp_rdata <= '0;
                state     <= S_RESP;
            end else if (advance) begin
                unique case (state)
                    S_IDLE: begin
                        // m_addr and m_tx_data double as the dev/reg latches.
                        rw_q      <= req_rw;
                        wdata_q   <= req_wdata;
                        rdata_q   <= '0;
                        err_q     <= 1'b0;
                        req_ready <= 1'b0;
                        m_addr    <= req_dev;
                        m_tx_data <= req_reg;
                        m_read    <= 1'b0;
                        m_stop    <= 1'b0;
                        m_start   <= 1'b1;
                        m_write   <= 1'b1;
                        state     <= S_ST_A;
                    end
                    S_ST_A: begin
                        m_start <= 1'b0;
                        state   <= S_PTR;
                    end
                    S_PTR, S_RADR: begin
                        if (!m_ack) begin
                            m_read  <= 1'b0;
                            m_write <= 1'b0;
                            m_stop  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state   <= S_STOP_F;
                        end else begin
                            state <= (state == S_PTR) ? S_PTR_ACK : S_RDAT;
                        end
                    end
                    S_PTR_ACK: begin
                        if (!m_ack) begin
                            m_read  <= 1'b0;
                            m_write <= 1'b0;
                            m_stop  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state   <= S_STOP_F;
                        end else if (rw_q) begin
                            // Pointer is set; close this leg, restart for the read.
                            m_write <= 1'b0;
                            m_stop  <= 1'b1;
                            state   <= S_STOP1;
                        end else begin
                            m_tx_data <= wdata_q;
                            state     <= S_WDAT;
                        end
                    end
                    S_WDAT: begin
                        // Same bus action either way; only the status differs.
                        err_q   <= !m_ack;
                        m_write <= 1'b0;
                        m_stop  <= 1'b1;
                        state   <= S_STOP_F;
                    end
                    S_STOP1: begin
                        m_stop  <= 1'b0;
                        m_read  <= 1'b1;
                        m_start <= 1'b1;
                        state   <= S_ST_B;
                    end
                    S_ST_B: begin
                        m_start <= 1'b0;
                        state   <= S_RADR;
                    end
                    S_RDAT: begin
                        // Single-byte read: master NACKs it and stops.
                        rdata_q <= m_rx_data;
                        m_read  <= 1'b0;
                        m_stop  <= 1'b1;
                        state   <= S_STOP_F;
                    end
                    S_STOP_F: begin
                        m_stop    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= {1'b0, err_q};
                        rsp_rdata <= err_q ? 8'd0 : rdata_q;
                        state     <= S_RESP;
                    end
                    default: begin  // S_RESP
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_sequencer
//
// Drives register requests into i2c_reg_sequencer, emulates an i2c_master
// plus a single slave at transaction level, and compares responses and the
// resulting bus transcript against a request-level reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

    localparam int TO      = 1000;
    localparam int CW      = 10;
    localparam int START_E = -1;
    localparam int STOP_E  = -2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       m_start, m_stop, m_read, m_write;
    logic [6:0] m_addr;
    logic [7:0] m_tx_data;
    logic       m_busy, m_ready, m_ack;
    logic [7:0] m_rx_data;

    i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_start(m_start), .m_stop(m_stop), .m_read(m_read), .m_write(m_write),
        .m_addr(m_addr), .m_tx_data(m_tx_data),
        .m_busy(m_busy), .m_ready(m_ready), .m_ack(m_ack), .m_rx_data(m_rx_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int ent(input logic a, input logic [7:0] b);
        return int'({a, b});
    endfunction

    // ---------------- slave configuration and bus transcript ----------------
    int         nack_at;      // index of slave-acked byte that is NACKed, -1 none
    logic [7:0] slave_data;
    bit         stall;        // hold SCL on the first STOP until the sequencer gives up
    int         byte_idx;
    int         bus_log[$];
    int         exp_bus[$];

    // ---------------- master emulation ----------------
    typedef enum {M_IDLE, M_STARTING, M_BYTE, M_DECIDE, M_STOPPING} mph_t;
    mph_t       mph;
    int         mcnt;
    logic [7:0] cur_byte;
    bit         cur_rx;

    initial begin : master
        m_busy = 1'b0; m_ready = 1'b0; m_ack = 1'b0; m_rx_data = 8'h00;
        mph = M_IDLE; mcnt = 0; cur_byte = 8'h00; cur_rx = 1'b0;
        forever begin
            @(negedge clk);
            m_ready = 1'b0;
            if (rst) begin
                m_busy = 1'b0; m_ack = 1'b0; mph = M_IDLE;
            end else begin
                case (mph)
                    M_IDLE: if (m_start) begin
                        mcnt = $urandom_range(1, 3);
                        mph  = M_STARTING;
                    end
                    M_STARTING: begin
                        mcnt--;
                        if (mcnt == 0) begin
                            if (!m_start) mph = M_IDLE;
                            else begin
                                m_busy   = 1'b1;
                                bus_log.push_back(START_E);
                                cur_byte = {m_addr, m_read};
                                cur_rx   = 1'b0;
                                mcnt     = $urandom_range(2, 5);
                                mph      = M_BYTE;
                            end
                        end
                    end
                    M_BYTE: begin
                        mcnt--;
                        if (mcnt == 0) begin
                            m_ready = 1'b1;
                            if (cur_rx) begin
                                m_rx_data = slave_data;
                                m_ack     = 1'b0;
                                bus_log.push_back(ent(1'b0, slave_data));
                            end else begin
                                m_ack = (byte_idx != nack_at);
                                bus_log.push_back(ent(m_ack, cur_byte));
                                byte_idx++;
                            end
                            mph = M_DECIDE;
                        end
                    end
                    M_DECIDE: begin
                        if (m_stop) begin
                            mcnt = $urandom_range(2, 4); mph = M_STOPPING;
                        end else if (m_write) begin
                            cur_byte = m_tx_data; cur_rx = 1'b0;
                            mcnt = $urandom_range(2, 5); mph = M_BYTE;
                        end else if (m_read) begin
                            cur_rx = 1'b1;
                            mcnt = $urandom_range(2, 5); mph = M_BYTE;
                        end else begin
                            m_busy = 1'b0; mph = M_IDLE;
                        end
                    end
                    default: begin  // M_STOPPING
                        if (stall) begin
                            if (!m_stop) begin
                                stall = 1'b0; m_busy = 1'b0;
                                bus_log.push_back(STOP_E); mph = M_IDLE;
                            end
                        end else begin
                            mcnt--;
                            if (mcnt == 0) begin
                                m_busy = 1'b0;
                                bus_log.push_back(STOP_E); mph = M_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- reference model (request level) ----------------
    task automatic model(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] sd, input int nk,
                         input bit st, output logic [1:0] e, output logic [7:0] rd);
        logic [7:0] wb[3];
        e = 2'd0; rd = 8'h00;
        exp_bus.delete();
        exp_bus.push_back(START_E);
        if (!rw) begin
            wb[0] = {dev, 1'b0}; wb[1] = rg; wb[2] = wd;
            for (int i = 0; i < 3; i++) begin
                exp_bus.push_back(ent(i != nk, wb[i]));
                if (i == nk) begin e = 2'd1; break; end
            end
            exp_bus.push_back(STOP_E);
        end else begin
            exp_bus.push_back(ent(nk != 0, {dev, 1'b0}));
            if (nk == 0) e = 2'd1;
            else begin
                exp_bus.push_back(ent(nk != 1, rg));
                if (nk == 1) e = 2'd1;
            end
            exp_bus.push_back(STOP_E);
            // A stall on the first STOP ends the transaction there.
            if (e == 2'd0 && !st) begin
                exp_bus.push_back(START_E);
                exp_bus.push_back(ent(nk != 2, {dev, 1'b1}));
                if (nk == 2) e = 2'd1;
                else begin
                    exp_bus.push_back(ent(1'b0, sd));
                    rd = sd;
                end
                exp_bus.push_back(STOP_E);
            end
        end
        if (st) begin e = 2'd2; rd = 8'h00; end
    endtask

    // ---------------- compare process ----------------
    int         cyc = 0;
    int         last_ev_cyc = 0;
    bit         in_flight = 1'b0;
    bit         exp_stall = 1'b0;
    logic [1:0] exp_err = 2'd0;
    logic [7:0] exp_rdata = 8'h00;
    int         rsp_count = 0;
    logic [1:0] got_err = 2'd0;
    logic [7:0] got_rdata = 8'h00;

    initial begin : compare
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                check("reset_outputs",
                      {req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_stop,
                       m_read, m_write, m_addr, m_tx_data}, {1'b1, 30'd0});
                in_flight = 1'b0;
            end else begin
                check("req_ready", req_ready, !in_flight);
                if (m_busy && m_ready && !m_ack)
                    check("nack_ev_ctrl", {m_start, m_stop, m_read, m_write}, 4'b0100);
                if (rsp_valid) begin
                    check("rsp_expected", in_flight, 1'b1);
                    check("rsp_err", rsp_err, exp_err);
                    check("rsp_rdata", rsp_rdata, exp_rdata);
                    check("rsp_ctrl_idle", {m_start, m_stop, m_read, m_write}, 4'b0000);
                    if (exp_stall) begin
                        check("timeout_latency", cyc - last_ev_cyc, TO);
                        check("timeout_addr_data", {m_addr, m_tx_data}, 15'd0);
                    end
                    got_err   = rsp_err;
                    got_rdata = rsp_rdata;
                    rsp_count++;
                    in_flight = 1'b0;
                end
                if (m_busy && m_ready) last_ev_cyc = cyc;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic [7:0] sd, input int nk,
                          input bit st, input bit rel_rst);
        logic [1:0] e;
        logic [7:0] rd;
        int t;
        int start_cnt;
        int diff;
        model(rw, dev, rg, wd, sd, nk, st, e, rd);
        @(negedge clk);
        if (rel_rst) rst = 1'b0;
        else begin
            t = 0;
            while (!req_ready && t < 200) begin @(negedge clk); t++; end
            check("req_ready_wait", req_ready, 1'b1);
        end
        nack_at = nk; slave_data = sd; stall = st; byte_idx = 0;
        bus_log.delete();
        exp_err = e; exp_rdata = rd; exp_stall = st;
        start_cnt = rsp_count;
        req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
        in_flight = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_dev = 7'($urandom); req_reg = 8'($urandom); req_wdata = 8'($urandom);
        t = 0;
        while (rsp_count == start_cnt && t < 3000) begin @(negedge clk); t++; end
        t = 0;
        while ((mph != M_IDLE || m_busy) && t < 200) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        check("rsp_count", rsp_count - start_cnt, 1);
        check("bus_len", bus_log.size(), exp_bus.size());
        diff = -1;
        for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++)
            if (diff < 0 && bus_log[i] != exp_bus[i]) diff = i;
        if (diff >= 0)
            $display("bus entry %0d: got 0x%0h want 0x%0h", diff, bus_log[diff], exp_bus[diff]);
        check("bus_seq_first_diff", diff, -1);
    endtask

    initial begin : stimulus
        int t;
        rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0;
        req_dev = '0; req_reg = '0; req_wdata = '0;
        nack_at = -1; slave_data = 8'h00; stall = 1'b0; byte_idx = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: plain write
        do_req(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 1'b0, 1'b0);
        check("t1_err", got_err, 2'd0);
        check("t1_rdata", got_rdata, 8'h00);
        check("t1_addr_byte", bus_log[1], 32'h1A0);
        check("t1_reg_byte", bus_log[2], 32'h110);
        check("t1_data_byte", bus_log[3], 32'h1A5);

        // 2: plain read
        do_req(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, 1'b0, 1'b0);
        check("t2_err", got_err, 2'd0);
        check("t2_rdata", got_rdata, 8'h3C);
        check("t2_restart", bus_log[4], START_E);
        check("t2_raddr_byte", bus_log[5], 32'h1A1);
        check("t2_rx_byte", bus_log[6], 32'h03C);

        // 3: absent device
        do_req(1'b0, 7'h31, 8'h10, 8'h77, 8'h00, 0, 1'b0, 1'b0);
        check("t3_err", got_err, 2'd1);
        check("t3_bus_len", bus_log.size(), 3);
        check("t3_addr_nack", bus_log[1], 32'h062);

        // 4: pointer NACK on a read
        do_req(1'b1, 7'h50, 8'h22, 8'h00, 8'h5A, 1, 1'b0, 1'b0);
        check("t4_err", got_err, 2'd1);
        check("t4_rdata", got_rdata, 8'h00);
        check("t4_bus_len", bus_log.size(), 4);

        // 5: stalled STOP -> timeout
        do_req(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 1'b1, 1'b0);
        check("t5_err", got_err, 2'd2);
        check("t5_rdata", got_rdata, 8'h00);

        // 6: reset while the read byte is in progress, then back-to-back write
        @(negedge clk);
        nack_at = -1; slave_data = 8'h99; stall = 1'b0; byte_idx = 0;
        req_valid = 1'b1; req_rw = 1'b1; req_dev = 7'h50; req_reg = 8'h44;
        in_flight = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!(mph == M_BYTE && cur_rx) && t < 500) begin @(negedge clk); t++; end
        check("t6_reached_rdat", mph == M_BYTE && cur_rx, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_req(1'b0, 7'h2A, 8'h05, 8'hC3, 8'h00, -1, 1'b0, 1'b1);
        check("t6_err", got_err, 2'd0);
        check("t6_rdata", got_rdata, 8'h00);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit   rw;
            int   nk;
            rw = 1'($urandom);
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            do_req(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   nk, (i % 20) == 7, 1'b0);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
